// File: rtl/store_monitor_if.sv
`default_nettype none
// ============================================================================
// Module      : store_monitor_if
// Description : Bundle of the store-bus and log-port signals between the
//               processor/consumer side (master) and store_monitor (slave).
//               master drives memwrite/dataadr/writedata/log_ready and
//               observes the verdict, counter and log outputs.
// Revision    : 1.0 - initial release
// ============================================================================
interface store_monitor_if;
  logic        memwrite;
  logic [31:0] dataadr;
  logic [31:0] writedata;
  logic        done;
  logic        pass;
  logic        fail;
  logic [1:0]  fail_code;
  logic [15:0] store_count;
  logic        log_valid;
  logic        log_ready;
  logic [31:0] log_addr;
  logic [31:0] log_data;
  logic        overflow;

  modport master (
    output memwrite, dataadr, writedata, log_ready,
    input  done, pass, fail, fail_code, store_count,
           log_valid, log_addr, log_data, overflow
  );

  modport slave (
    input  memwrite, dataadr, writedata, log_ready,
    output done, pass, fail, fail_code, store_count,
           log_valid, log_addr, log_data, overflow
  );
endinterface
`default_nettype wire

// File: rtl/store_monitor.sv
`default_nettype none
// ============================================================================
// Module      : store_monitor
// Description : Watches the data-memory store bus, classifies each store as
//               scratch / pass-signature / illegal, latches a sticky verdict,
//               enforces a run timeout and logs accepted stores in a
//               first-word-fall-through FIFO drained over valid/ready.
// Ports       : clk    - system clock, rising edge
//               reset  - asynchronous, active-low reset
//               bus    - store_monitor_if.slave: store strobe/address/data in,
//                        verdict (done/pass/fail/fail_code), store_count,
//                        log port (log_valid/log_ready/log_addr/log_data),
//                        overflow out
// Revision    : 1.0 - initial release
// ============================================================================
module store_monitor #(
  parameter logic [31:0] PASS_ADDR     = 32'd84,
  parameter logic [31:0] PASS_DATA     = 32'd7,
  parameter logic [31:0] PASS_DATA_ALT = 32'hFFFF7F02,
  parameter logic [31:0] SCRATCH_ADDR  = 32'd80,
  parameter int          DEPTH         = 8,
  parameter int          TIMEOUT       = 1000
) (
  input  wire logic       clk,
  input  wire logic       reset,
  store_monitor_if.slave  bus
);

  localparam int c_aw = $clog2(DEPTH);
  localparam int c_tw = $clog2(TIMEOUT + 1);
  localparam logic [c_tw-1:0] c_tlast = c_tw'(TIMEOUT - 1);
  localparam logic [c_aw:0]   c_full  = (c_aw+1)'(DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t          r_state;
  logic [c_tw-1:0] r_timer;
  logic            r_done;
  logic            r_pass;
  logic            r_fail;
  logic [1:0]      r_fail_code;
  logic [15:0]     r_store_count;
  logic            r_overflow;
  logic [c_aw-1:0] r_wr;
  logic [c_aw-1:0] r_rd;
  logic [c_aw:0]   r_cnt;
  logic [63:0]     r_mem [DEPTH];

  logic w_store;
  logic w_known;
  logic w_sig;
  logic w_scr;
  logic w_timeout;
  logic w_full;
  logic w_pop;
  logic w_push;

  // Stores are only sampled while running; an X strobe reads as no store.
  assign w_store   = (r_state == ST_RUN) && (bus.memwrite == 1'b1);
  // Unknown address/data bits force the illegal classification.
  assign w_known   = ((^{bus.dataadr, bus.writedata}) !== 1'bx);
  assign w_sig     = w_known && (bus.dataadr == PASS_ADDR) &&
                     ((bus.writedata == PASS_DATA) || (bus.writedata == PASS_DATA_ALT));
  assign w_scr     = w_known && (bus.dataadr == SCRATCH_ADDR);
  // r_timer holds the number of RUN edges already taken, so this edge is
  // the TIMEOUT-th one when it equals TIMEOUT-1.
  assign w_timeout = (r_state == ST_RUN) && (r_timer == c_tlast);

  assign w_full = (r_cnt == c_full);
  assign w_pop  = (r_cnt != '0) && bus.log_ready;
  // A full FIFO still accepts a store when its head leaves on the same edge.
  assign w_push = w_store && (!w_full || w_pop);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state       <= ST_IDLE;
      r_timer       <= '0;
      r_done        <= 1'b0;
      r_pass        <= 1'b0;
      r_fail        <= 1'b0;
      r_fail_code   <= 2'd0;
      r_store_count <= 16'd0;
      r_overflow    <= 1'b0;
      r_wr          <= '0;
      r_rd          <= '0;
      r_cnt         <= '0;
    end else begin
      // FIFO pointers keep moving in every state so draining continues
      // after the verdict.
      if (w_push) r_wr <= r_wr + 1'b1;
      if (w_pop)  r_rd <= r_rd + 1'b1;
      if (w_push && !w_pop)      r_cnt <= r_cnt + 1'b1;
      else if (!w_push && w_pop) r_cnt <= r_cnt - 1'b1;

      case (r_state)
        ST_IDLE: begin
          r_state <= ST_RUN;
          r_timer <= '0;
        end
        ST_RUN: begin
          r_timer <= r_timer + 1'b1;
          if (w_store) begin
            if (r_store_count != 16'hFFFF) r_store_count <= r_store_count + 16'd1;
            if (!w_push) r_overflow <= 1'b1;
          end
          if (w_store && w_sig) begin
            r_pass  <= 1'b1;
            r_done  <= 1'b1;
            r_state <= ST_DONE;
          end else if (w_store && !w_scr) begin
            r_fail      <= 1'b1;
            r_fail_code <= 2'd1;
            r_done      <= 1'b1;
            r_state     <= ST_DONE;
          end else if (w_timeout) begin
            r_fail      <= 1'b1;
            r_fail_code <= 2'd2;
            r_done      <= 1'b1;
            r_state     <= ST_DONE;
          end
        end
        default: begin
          r_state <= ST_DONE;
        end
      endcase
    end
  end

  // Log storage needs no reset: entries are only visible through log_valid.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr] <= {bus.dataadr, bus.writedata};
  end

  assign bus.done        = r_done;
  assign bus.pass        = r_pass;
  assign bus.fail        = r_fail;
  assign bus.fail_code   = r_fail_code;
  assign bus.store_count = r_store_count;
  assign bus.overflow    = r_overflow;
  assign bus.log_valid   = (r_cnt != '0);
  assign bus.log_addr    = (r_cnt != '0) ? r_mem[r_rd][63:32] : 32'd0;
  assign bus.log_data    = (r_cnt != '0) ? r_mem[r_rd][31:0]  : 32'd0;

endmodule
`default_nettype wire

// File: tb/tb_store_monitor.sv
`default_nettype none
// ============================================================================
// Module      : tb_store_monitor
// Description : Self-checking bench for store_monitor. A behavioural model
//               (queue-based log, plain counters, verdict flags) is advanced
//               once per clock edge and compared with the DUT on every
//               falling edge; directed scenarios add literal expectations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_store_monitor;

  localparam int DEPTH   = 8;
  localparam int TIMEOUT = 1000;

  logic clk;
  logic reset;
  store_monitor_if bus();

  store_monitor #(
    .PASS_ADDR     (32'd84),
    .PASS_DATA     (32'd7),
    .PASS_DATA_ALT (32'hFFFF7F02),
    .SCRATCH_ADDR  (32'd80),
    .DEPTH         (DEPTH),
    .TIMEOUT       (TIMEOUT)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  bit check_en = 1'b0;

  // Behavioural model
  int          m_phase;      // 0 waiting for first edge, 1 running, 2 verdict
  int          m_edges;      // edges spent running
  bit          m_pass, m_fail, m_ovf;
  int          m_code;
  int          m_count;
  logic [63:0] m_q[$];

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    m_phase = 0; m_edges = 0; m_pass = 0; m_fail = 0; m_ovf = 0;
    m_code = 0; m_count = 0; m_q.delete();
  endtask

  task automatic model_edge(logic mw, logic [31:0] a, logic [31:0] d, logic rdy);
    bit popped;
    popped = (m_q.size() > 0) && rdy;
    if (popped) void'(m_q.pop_front());
    if (m_phase == 0) begin
      m_phase = 1;
      m_edges = 0;
    end else if (m_phase == 1) begin
      m_edges++;
      if (mw) begin
        if (m_count < 65535) m_count++;
        if (m_q.size() < DEPTH) m_q.push_back({a, d});
        else m_ovf = 1;
        if (a == 32'd84 && (d == 32'd7 || d == 32'hFFFF7F02)) begin
          m_pass = 1; m_phase = 2;
        end else if (a != 32'd80) begin
          m_fail = 1; m_code = 1; m_phase = 2;
        end
      end
      if (m_phase == 1 && m_edges == TIMEOUT) begin
        m_fail = 1; m_code = 2; m_phase = 2;
      end
    end
  endtask

  task automatic step(logic mw, logic [31:0] a, logic [31:0] d, logic rdy);
    bus.memwrite  = mw;
    bus.dataadr   = a;
    bus.writedata = d;
    bus.log_ready = rdy;
    @(posedge clk);
    model_edge(mw, a, d, rdy);
    @(negedge clk);
  endtask

  // Reset asserted between edges; outputs must clear without a clock edge.
  task automatic do_reset();
    check_en = 1'b0;
    #2;
    reset = 1'b0;
    bus.memwrite = 1'b0;
    bus.log_ready = 1'b0;
    #1;
    chk("rst_done",  bus.done, 0);
    chk("rst_pass",  bus.pass, 0);
    chk("rst_fail",  bus.fail, 0);
    chk("rst_code",  bus.fail_code, 0);
    chk("rst_count", bus.store_count, 0);
    chk("rst_valid", bus.log_valid, 0);
    chk("rst_ovf",   bus.overflow, 0);
    chk("rst_laddr", bus.log_addr, 0);
    chk("rst_ldata", bus.log_data, 0);
    model_clear();
    @(negedge clk);
    #2;
    reset = 1'b1;
    check_en = 1'b1;
  endtask

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    if (check_en) begin
      chk("done",      bus.done, 32'(m_pass | m_fail));
      chk("pass",      bus.pass, 32'(m_pass));
      chk("fail",      bus.fail, 32'(m_fail));
      chk("fail_code", bus.fail_code, 32'(m_code));
      chk("count",     bus.store_count, 32'(m_count));
      chk("log_valid", bus.log_valid, 32'(m_q.size() != 0));
      chk("overflow",  bus.overflow, 32'(m_ovf));
      if (m_q.size() != 0) begin
        chk("log_addr", bus.log_addr, m_q[0][63:32]);
        chk("log_data", bus.log_data, m_q[0][31:0]);
      end
    end
  end

  task automatic run_one();
    step(0, 0, 0, 0);
    step(1, 32'd80, 32'd5, 0);
    step(1, 32'd80, 32'd9, 0);
    chk("t1_pass_early", bus.pass, 0);
    step(1, 32'd84, 32'd7, 0);
    chk("t1_pass",  bus.pass, 1);
    chk("t1_count", bus.store_count, 3);
    chk("t1_code",  bus.fail_code, 0);
    chk("t1_h0a",   bus.log_addr, 80);
    chk("t1_h0d",   bus.log_data, 5);
    step(0, 0, 0, 1);
    chk("t1_h1d",   bus.log_data, 9);
    step(0, 0, 0, 1);
    chk("t1_h2a",   bus.log_addr, 84);
    chk("t1_h2d",   bus.log_data, 7);
    step(0, 0, 0, 1);
    chk("t1_empty", bus.log_valid, 0);
  endtask

  initial begin
    reset = 1'b0;
    bus.memwrite = 1'b0;
    bus.dataadr = '0;
    bus.writedata = '0;
    bus.log_ready = 1'b0;
    model_clear();

    // 1: scratch stores then signature
    do_reset();
    run_one();

    // 2: alternate signature, later store ignored
    do_reset();
    step(0, 0, 0, 0);
    step(1, 32'd84, 32'hFFFF7F02, 0);
    chk("t2_pass", bus.pass, 1);
    step(1, 32'd84, 32'd3, 0);
    chk("t2_count", bus.store_count, 1);
    chk("t2_fail",  bus.fail, 0);

    // 3: illegal store
    do_reset();
    step(0, 0, 0, 0);
    step(1, 32'd60, 32'd7, 0);
    chk("t3_fail", bus.fail, 1);
    chk("t3_code", bus.fail_code, 1);
    chk("t3_done", bus.done, 1);
    chk("t3_pass", bus.pass, 0);

    // 4: timeout, and a signature store on the timeout edge
    do_reset();
    step(0, 0, 0, 0);
    for (int i = 0; i < TIMEOUT - 1; i++) step(0, 0, 0, 0);
    chk("t4_nofail", bus.fail, 0);
    step(0, 0, 0, 0);
    chk("t4_fail", bus.fail, 1);
    chk("t4_code", bus.fail_code, 2);
    do_reset();
    step(0, 0, 0, 0);
    for (int i = 0; i < TIMEOUT - 1; i++) step(0, 0, 0, 0);
    step(1, 32'd84, 32'd7, 0);
    chk("t4_pass",  bus.pass, 1);
    chk("t4_fail2", bus.fail, 0);

    // 5: overflow with consumer stalled
    do_reset();
    step(0, 0, 0, 0);
    for (int i = 0; i < 9; i++) step(1, 32'd80, 32'(i), 0);
    chk("t5_ovf",   bus.overflow, 1);
    chk("t5_count", bus.store_count, 9);
    chk("t5_head",  bus.log_data, 0);
    // 5b: push and pop on the same edge while full
    do_reset();
    step(0, 0, 0, 0);
    for (int i = 0; i < 8; i++) step(1, 32'd80, 32'(i), 0);
    step(1, 32'd80, 32'hAA, 1);
    chk("t5b_ovf",  bus.overflow, 0);
    chk("t5b_head", bus.log_data, 1);
    for (int i = 0; i < 8; i++) step(0, 0, 0, 1);
    chk("t5b_empty", bus.log_valid, 0);

    // 6: reset mid-run, then scenario 1 again
    do_reset();
    step(0, 0, 0, 0);
    step(1, 32'd80, 32'd1, 0);
    step(1, 32'd80, 32'd2, 0);
    do_reset();
    run_one();

    // Randomized rounds
    for (int r = 0; r < 12; r++) begin
      do_reset();
      step(0, 0, 0, 0);
      for (int c = 0; c < 300; c++) begin
        logic        mw;
        logic [31:0] a, d;
        int          sel;
        mw  = ($urandom_range(0, 2) == 0);
        sel = $urandom_range(0, 19);
        if (sel < 16)      a = 32'd80;
        else if (sel < 18) a = 32'd84;
        else if (sel < 19) a = 32'd60;
        else               a = $urandom;
        case ($urandom_range(0, 3))
          0:       d = 32'd7;
          1:       d = 32'hFFFF7F02;
          default: d = $urandom;
        endcase
        step(mw, a, d, logic'($urandom_range(0, 1)));
      end
    end

    check_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
